simd_mac_fu: RTL and testbench

Parametrised SIMD dot-product/multiply-accumulate functional unit for the CVA6 execute stage. It is the successor to the fixed 4×8-bit MAC unit and adds the following:
- configurable element width and lane count;
- per-instruction signedness of operand B;
- a two-stage pipeline with flush;
- a non-accumulating DOT operation and a READ operation;
- sticky overflow detection, with optional saturation.

It is issued like any other FU and writes back through its own valid/trans_id port.

---
 rtl/simd_mac_fu_if.sv | 26 ++
 rtl/simd_mac_fu.sv | 143 ++++++++++++++
 tb/tb_simd_mac_fu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/simd_mac_fu_if.sv
// Issue and write-back bundle of the SIMD MAC functional unit; slave is the FU side.
interface simd_mac_fu_if #(
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3
);
    logic                     valid_i;
    logic                     ready_o;
    logic [1:0]               operation_i;
    logic                     b_signed_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic [XLEN-1:0]          result_o;
    logic                     valid_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    modport slave (
        input  valid_i, operation_i, b_signed_i, operand_a_i, operand_b_i, trans_id_i,
        output ready_o, result_o, valid_o, trans_id_o
    );

    modport master (
        output valid_i, operation_i, b_signed_i, operand_a_i, operand_b_i, trans_id_i,
        input  ready_o, result_o, valid_o, trans_id_o
    );
endinterface

// File: rtl/simd_mac_fu.sv
// SIMD dot-product / MAC unit, 2-cycle latency, 1 op/cycle, never backpressures (ready_o = 1).
// Define MAC_SAT_EN to saturate the accumulator on ACC overflow instead of wrapping.
module simd_mac_fu #(
    parameter int XLEN          = 32,
    parameter int ELEM_W        = 8,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    simd_mac_fu_if.slave      fu_io,
    output logic              ovf_o
);
    localparam int LANES = XLEN / ELEM_W;
    localparam int PW    = 2 * ELEM_W + 2;
    localparam int SW    = PW + $clog2(LANES);

    typedef enum logic [1:0] {OP_INIT = 2'b00, OP_ACC = 2'b01, OP_DOT = 2'b10, OP_READ = 2'b11} op_e;

    logic                          accept;
    logic [LANES-1:0][PW-1:0]      prod_d, prod_q;
    logic                          s1_vld_q;
    op_e                           s1_op_q;
    logic [TRANS_ID_BITS-1:0]      s1_tid_q;
    logic [XLEN-1:0]               s1_a_q;

    logic signed [PW-1:0]          a_x, b_x;
    logic signed [SW-1:0]          dot_sum;
    logic signed [XLEN:0]          dot_x, acc_x, sum_x;
    logic                          sum_ovf;
    logic [XLEN-1:0]               acc_new;
    logic                          fire;

    logic [XLEN-1:0]               acc_d, acc_q;
    logic                          ovf_d, ovf_q;
    logic [XLEN-1:0]               res_d, res_q;
    logic [TRANS_ID_BITS-1:0]      tid_d, tid_q;
    logic                          vld_d, vld_q;

    assign accept = fu_io.valid_i & ~flush_i;

    // A lanes are always signed; B lanes are sign- or zero-extended per instruction.
    always_comb begin
        prod_d = '0;
        a_x    = '0;
        b_x    = '0;
        for (int i = 0; i < LANES; i++) begin
            a_x = {{(PW-ELEM_W){fu_io.operand_a_i[i*ELEM_W+ELEM_W-1]}},
                   fu_io.operand_a_i[i*ELEM_W +: ELEM_W]};
            b_x = {{(PW-ELEM_W){fu_io.b_signed_i & fu_io.operand_b_i[i*ELEM_W+ELEM_W-1]}},
                   fu_io.operand_b_i[i*ELEM_W +: ELEM_W]};
            prod_d[i] = a_x * b_x;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= OP_INIT;
            s1_tid_q <= '0;
            s1_a_q   <= '0;
            prod_q   <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_op_q  <= op_e'(fu_io.operation_i);
                s1_tid_q <= fu_io.trans_id_i;
                s1_a_q   <= fu_io.operand_a_i;
                prod_q   <= prod_d;
            end
        end
    end

    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_sum = dot_sum + SW'($signed(prod_q[i]));
        end
        dot_x   = (XLEN+1)'(dot_sum);
        acc_x   = (XLEN+1)'($signed(acc_q));
        sum_x   = acc_x + dot_x;
        sum_ovf = sum_x[XLEN] ^ sum_x[XLEN-1];
`ifdef MAC_SAT_EN
        // The XLEN+1-bit sum cannot itself overflow, so its MSB gives the true sign.
        if (sum_ovf) begin
            acc_new = sum_x[XLEN] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end else begin
            acc_new = sum_x[XLEN-1:0];
        end
`else
        acc_new = sum_x[XLEN-1:0];
`endif
    end

    assign fire = s1_vld_q & ~flush_i;

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        res_d = res_q;
        tid_d = tid_q;
        vld_d = fire;
        if (fire) begin
            tid_d = s1_tid_q;
            case (s1_op_q)
                OP_INIT: begin
                    acc_d = s1_a_q;
                    ovf_d = 1'b0;
                    res_d = s1_a_q;
                end
                OP_ACC: begin
                    acc_d = acc_new;
                    ovf_d = ovf_q | sum_ovf;
                    res_d = acc_new;
                end
                OP_DOT:  res_d = dot_x[XLEN-1:0];
                OP_READ: res_d = acc_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            res_q <= '0;
            tid_q <= '0;
            vld_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            res_q <= res_d;
            tid_q <= tid_d;
            vld_q <= vld_d;
        end
    end

    assign fu_io.ready_o    = 1'b1;
    assign fu_io.result_o   = res_q;
    assign fu_io.valid_o    = vld_q;
    assign fu_io.trans_id_o = tid_q;
    assign ovf_o            = ovf_q;
endmodule

// File: tb/tb_simd_mac_fu.sv
// Randomized and directed bench for simd_mac_fu against an integer reference model.
module tb_simd_mac_fu;
    localparam int XLEN   = 32;
    localparam int ELEM_W = 8;
    localparam int LANES  = XLEN / ELEM_W;
    localparam int TIDW   = 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic ovf;

    simd_mac_fu_if #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW)) mi ();

    simd_mac_fu #(.XLEN(XLEN), .ELEM_W(ELEM_W), .TRANS_ID_BITS(TIDW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .fu_io   (mi),
        .ovf_o   (ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    longint          m_acc;
    bit              m_ovf;
    bit              p_vld;
    logic [1:0]      p_op;
    logic [XLEN-1:0] p_a, p_b;
    bit              p_bs;
    logic [TIDW-1:0] p_tid;
    bit              e_vld;
    logic [XLEN-1:0] e_res;
    logic [TIDW-1:0] e_tid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint dot_ref(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit bs);
        longint s = 0;
        logic [ELEM_W-1:0] al, bl;
        for (int i = 0; i < LANES; i++) begin
            al = a[i*ELEM_W +: ELEM_W];
            bl = b[i*ELEM_W +: ELEM_W];
            if (bs) s += longint'($signed(al)) * longint'($signed(bl));
            else    s += longint'($signed(al)) * longint'(bl);
        end
        return s;
    endfunction

    task automatic model_edge(input bit r, input bit f, input bit v, input logic [1:0] op,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input bit bs, input logic [TIDW-1:0] tid);
        longint s, d;
        if (r) begin
            m_acc = 0; m_ovf = 0; p_vld = 0;
            e_vld = 0; e_res = '0; e_tid = '0;
            return;
        end
        e_vld = 0;
        if (p_vld && !f) begin
            e_vld = 1;
            e_tid = p_tid;
            d = dot_ref(p_a, p_b, p_bs);
            case (p_op)
                2'b00: begin m_acc = longint'($signed(p_a)); m_ovf = 0; e_res = p_a; end
                2'b01: begin
                    s = m_acc + d;
                    if (s > SMAX || s < SMIN) begin
                        m_ovf = 1;
`ifdef MAC_SAT_EN
                        m_acc = (s > SMAX) ? SMAX : SMIN;
`else
                        m_acc = longint'($signed(s[XLEN-1:0]));
`endif
                    end else begin
                        m_acc = s;
                    end
                    e_res = m_acc[XLEN-1:0];
                end
                2'b10: e_res = d[XLEN-1:0];
                default: e_res = m_acc[XLEN-1:0];
            endcase
        end
        p_vld = v && !f;
        if (p_vld) begin
            p_op = op; p_a = a; p_b = b; p_bs = bs; p_tid = tid;
        end
    endtask

    task automatic step(input bit r, input bit f, input bit v, input logic [1:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit bs, input logic [TIDW-1:0] tid);
        rst = r; flush = f;
        mi.valid_i = v; mi.operation_i = op; mi.operand_a_i = a;
        mi.operand_b_i = b; mi.b_signed_i = bs; mi.trans_id_i = tid;
        @(posedge clk);
        model_edge(r, f, v, op, a, b, bs, tid);
        @(negedge clk);
        chk("valid_o", 64'(mi.valid_o), 64'(e_vld));
        chk("result_o", 64'(mi.result_o), 64'(e_res));
        chk("trans_id_o", 64'(mi.trans_id_o), 64'(e_tid));
        chk("ovf_o", 64'(ovf), 64'(m_ovf));
        chk("ready_o", 64'(mi.ready_o), 64'd1);
    endtask

    task automatic idle();
        step(0, 0, 0, 2'b00, '0, '0, 0, '0);
    endtask

    task automatic op1(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit bs, input logic [TIDW-1:0] tid);
        step(0, 0, 1, op, a, b, bs, tid);
        idle();
    endtask

    initial begin
        m_acc = 0; m_ovf = 0; p_vld = 0; e_vld = 0; e_res = '0; e_tid = '0;
        p_op = '0; p_a = '0; p_b = '0; p_bs = 0; p_tid = '0;
        step(1, 0, 0, 2'b00, '0, '0, 0, '0);
        step(1, 0, 0, 2'b00, '0, '0, 0, '0);
        chk("rst_valid", 64'(mi.valid_o), 64'd0);
        chk("rst_result", 64'(mi.result_o), 64'd0);

        op1(2'b00, 32'd5, '0, 0, 3'd0);
        chk("tp1_init", 64'(mi.result_o), 64'h5);
        op1(2'b01, 32'h01020304, 32'h01010101, 0, 3'd1);
        chk("tp1_acc", 64'(mi.result_o), 64'hF);
        chk("tp1_ovf", 64'(ovf), 64'd0);

        op1(2'b00, 32'd0, '0, 0, 3'd2);
        op1(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 3'd3);
        chk("tp2_unsigned", 64'(mi.result_o), 64'hFFFFFC04);
        op1(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 3'd4);
        chk("tp2_signed", 64'(mi.result_o), 64'hFFFFFC08);

        op1(2'b00, 32'h7FFFFFF0, '0, 0, 3'd5);
        op1(2'b01, 32'h7F7F7F7F, 32'hFFFFFFFF, 0, 3'd6);
`ifdef MAC_SAT_EN
        chk("tp3_sat", 64'(mi.result_o), 64'h7FFFFFFF);
`else
        chk("tp3_wrap", 64'(mi.result_o), 64'h8001F9F4);
`endif
        chk("tp3_ovf", 64'(ovf), 64'd1);
        op1(2'b00, 32'd0, '0, 0, 3'd7);
        chk("tp3_ovf_clr", 64'(ovf), 64'd0);

        op1(2'b00, 32'd0, '0, 0, 3'd0);
        step(0, 0, 1, 2'b01, 32'h01010101, 32'h01010101, 0, 3'd1);
        step(0, 0, 1, 2'b01, 32'h01010101, 32'h01010101, 0, 3'd2);
        chk("tp4_res1", 64'(mi.result_o), 64'd4);
        chk("tp4_tid1", 64'(mi.trans_id_o), 64'd1);
        step(0, 0, 1, 2'b01, 32'h01010101, 32'h01010101, 0, 3'd3);
        chk("tp4_res2", 64'(mi.result_o), 64'd8);
        idle();
        chk("tp4_res3", 64'(mi.result_o), 64'd12);
        chk("tp4_tid3", 64'(mi.trans_id_o), 64'd3);
        chk("tp4_vld3", 64'(mi.valid_o), 64'd1);

        op1(2'b00, 32'd15, '0, 0, 3'd0);
        step(0, 0, 1, 2'b01, 32'h01010101, 32'h01010101, 0, 3'd1);
        step(0, 1, 0, 2'b00, '0, '0, 0, '0);
        chk("tp5_flush_vld", 64'(mi.valid_o), 64'd0);
        idle();
        chk("tp5_flush_vld2", 64'(mi.valid_o), 64'd0);
        op1(2'b11, '0, '0, 0, 3'd2);
        chk("tp5_read", 64'(mi.result_o), 64'd15);
        op1(2'b10, 32'd2, 32'd3, 0, 3'd3);
        chk("tp5_dot", 64'(mi.result_o), 64'd6);
        op1(2'b11, '0, '0, 0, 3'd4);
        chk("tp5_acc_kept", 64'(mi.result_o), 64'd15);

        step(0, 0, 1, 2'b01, 32'h01010101, 32'h01010101, 0, 3'd5);
        step(1, 0, 0, 2'b00, '0, '0, 0, '0);
        idle();
        chk("tp6_no_vld", 64'(mi.valid_o), 64'd0);
        op1(2'b11, '0, '0, 0, 3'd6);
        chk("tp6_read", 64'(mi.result_o), 64'd0);
        chk("tp6_ovf", 64'(ovf), 64'd0);

        for (int k = 0; k < 1500; k++) begin
            logic [1:0]      r_op;
            logic [XLEN-1:0] r_a;
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if (r_op == 2'b00 && $urandom_range(0, 1) == 1)
                r_a = {($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000, 16'($urandom)};
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, r_op, r_a, $urandom,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
